// File: rtl/response_fault_injector_pkg.sv
// Shared types for the PSL response fault injector: response codes, the
// response interface record, window descriptors and injector states.
package response_fault_injector_pkg;

    localparam int unsigned DEFAULT_NUM_WINDOWS       = 4;
    localparam int unsigned DEFAULT_COUNT_WIDTH       = 16;
    localparam int unsigned DEFAULT_HOLDOFF_RESPONSES = 8;

    // Window bounds are stored at full width; narrower counters are
    // zero-extended before comparison, so out-of-range bounds never alias.
    localparam int unsigned MAX_COUNT_WIDTH = 16;

    // PSL response codes.
    typedef enum logic [7:0] {
        RESP_DONE    = 8'h00,
        RESP_AERROR  = 8'h01,
        RESP_DERROR  = 8'h03,
        RESP_NLOCK   = 8'h04,
        RESP_NRES    = 8'h05,
        RESP_FLUSHED = 8'h06,
        RESP_FAULT   = 8'h07,
        RESP_FAILED  = 8'h08,
        RESP_PAGED   = 8'h0A,
        RESP_CONTEXT = 8'h0B
    } resp_code_e;

    // Raw PSL response as seen by the AFU.
    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic        tag_parity;
        logic [7:0]  response;
        logic [8:0]  credits;
        logic [1:0]  cache_state;
        logic [12:0] cache_pos;
    } response_interface_t;

    // One programmable injection window.
    typedef struct packed {
        logic                       enable;
        logic [MAX_COUNT_WIDTH-1:0] lo;
        logic [MAX_COUNT_WIDTH-1:0] hi;
        resp_code_e                 code;
    } fault_window_t;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_HOLDOFF  = 2'd2
    } injector_state_e;

    // A window matches when enabled and lo <= count <= hi; lo > hi never matches.
    function automatic logic window_matches(input fault_window_t w,
                                            input logic [MAX_COUNT_WIDTH-1:0] count);
        return w.enable && (w.lo <= count) && (count <= w.hi);
    endfunction

endpackage

// File: rtl/response_fault_injector_window_match.sv
// Combinational priority match of the response count against all windows;
// the lowest-indexed matching window supplies the replacement code.
module fault_window_match
    import response_fault_injector_pkg::*;
#(
    parameter int unsigned NUM_WINDOWS = DEFAULT_NUM_WINDOWS,
    parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  fault_window_t [NUM_WINDOWS-1:0] windows_in,
    input  logic [COUNT_WIDTH-1:0]          count_in,
    input  logic                            eligible_in,
    output logic                            hit_out,
    output resp_code_e                      code_out
);

    logic [MAX_COUNT_WIDTH-1:0] count_ext;

    assign count_ext = MAX_COUNT_WIDTH'(count_in);

    // Priority encode: first match from index 0 upwards wins.
    always_comb begin
        hit_out  = 1'b0;
        code_out = RESP_DONE;
        for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
            if (!hit_out && eligible_in && window_matches(windows_in[i], count_ext)) begin
                hit_out  = 1'b1;
                code_out = windows_in[i].code;
            end
        end
    end

endmodule

// File: rtl/response_fault_injector.sv
// Registered PSL response stage that counts valid responses and overwrites
// DONE codes with a programmed error inside MMIO-configured count windows.
module response_fault_injector
    import response_fault_injector_pkg::*;
#(
    parameter int unsigned NUM_WINDOWS       = DEFAULT_NUM_WINDOWS,
    parameter int unsigned COUNT_WIDTH       = DEFAULT_COUNT_WIDTH,
    parameter int unsigned HOLDOFF_RESPONSES = DEFAULT_HOLDOFF_RESPONSES
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           enabled_in,
    input  response_interface_t            response_in,
    input  logic                           cfg_write,
    input  logic [$clog2(NUM_WINDOWS)-1:0] cfg_index,
    input  fault_window_t                  cfg_window,
    output response_interface_t            response_out,
    output logic [COUNT_WIDTH-1:0]         response_count_out,
    output logic [31:0]                    inject_count_out,
    output logic                           holdoff_out
);

    localparam int unsigned HOLD_W = $clog2(HOLDOFF_RESPONSES + 2);

    injector_state_e                 state_q, state_d;
    response_interface_t             response_q, response_d;
    logic [COUNT_WIDTH-1:0]          count_q, count_d;
    logic [31:0]                     inject_q, inject_d;
    logic [HOLD_W-1:0]               holdoff_cnt_q, holdoff_cnt_d;
    fault_window_t [NUM_WINDOWS-1:0] windows_q, windows_d;
    logic                            enabled_prev_q, enabled_prev_d;

    logic       match_eligible;
    logic       match_hit;
    resp_code_e match_code;

    // Only genuine DONE responses seen while ACTIVE may be overwritten.
    assign match_eligible = (state_q == ST_ACTIVE) && response_in.valid &&
                            (response_in.response == RESP_DONE);

    fault_window_match #(
        .NUM_WINDOWS (NUM_WINDOWS),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_match (
        .windows_in  (windows_q),
        .count_in    (count_q),
        .eligible_in (match_eligible),
        .hit_out     (match_hit),
        .code_out    (match_code)
    );

    // Next-state, counter, window and output-register computation.
    always_comb begin
        state_d        = state_q;
        response_d     = response_in;
        count_d        = count_q;
        inject_d       = inject_q;
        holdoff_cnt_d  = holdoff_cnt_q;
        windows_d      = windows_q;
        enabled_prev_d = enabled_in;

        // Matching above uses windows_q, so a same-cycle write only affects
        // later responses.
        if (cfg_write) begin
            windows_d[cfg_index] = cfg_window;
        end

        case (state_q)
            ST_DISABLED: begin
                if (enabled_in && !enabled_prev_q) begin
                    count_d  = '0;
                    inject_d = '0;
                    state_d  = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (response_in.valid) begin
                    if (count_q != '1) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                    if (match_hit) begin
                        response_d.response = match_code;
                        if (inject_q != '1) begin
                            inject_d = inject_q + 32'd1;
                        end
                        if (match_code == RESP_PAGED && HOLDOFF_RESPONSES != 0) begin
                            state_d       = ST_HOLDOFF;
                            holdoff_cnt_d = HOLD_W'(HOLDOFF_RESPONSES);
                        end
                    end
                end
                if (!enabled_in) begin
                    state_d = ST_DISABLED;
                end
            end

            ST_HOLDOFF: begin
                if (response_in.valid) begin
                    if (count_q != '1) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                    holdoff_cnt_d = holdoff_cnt_q - HOLD_W'(1);
                    if (holdoff_cnt_q == HOLD_W'(1)) begin
                        state_d = ST_ACTIVE;
                    end
                end
                if (!enabled_in) begin
                    state_d = ST_DISABLED;
                end
            end

            default: begin
                state_d = ST_DISABLED;
            end
        endcase
    end

    // State, counters, windows and the response output register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q        <= ST_DISABLED;
            response_q     <= '0;
            count_q        <= '0;
            inject_q       <= '0;
            holdoff_cnt_q  <= '0;
            windows_q      <= '0;
            enabled_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            response_q     <= response_d;
            count_q        <= count_d;
            inject_q       <= inject_d;
            holdoff_cnt_q  <= holdoff_cnt_d;
            windows_q      <= windows_d;
            enabled_prev_q <= enabled_prev_d;
        end
    end

    assign response_out       = response_q;
    assign response_count_out = count_q;
    assign inject_count_out   = inject_q;
    assign holdoff_out        = (state_q == ST_HOLDOFF);

endmodule

// File: tb/tb_response_fault_injector.sv
// Directed bench for response_fault_injector: pass-through, window ranges,
// priority, holdoff, boundaries, enable toggling and async reset.
module tb_response_fault_injector;
    import response_fault_injector_pkg::*;

    logic                clock;
    logic                rst;
    logic                enabled_in;
    response_interface_t response_in;
    logic                cfg_write;
    logic [1:0]          cfg_index;
    fault_window_t       cfg_window;
    response_interface_t response_out;
    logic [15:0]         response_count_out;
    logic [31:0]         inject_count_out;
    logic                holdoff_out;

    response_interface_t resp4_out;
    logic [3:0]          count4_out;
    logic [31:0]         inject4_out;
    logic                holdoff4_out;

    int compared   = 0;
    int mismatched = 0;

    response_fault_injector #(
        .NUM_WINDOWS       (4),
        .COUNT_WIDTH       (16),
        .HOLDOFF_RESPONSES (8)
    ) dut (
        .clock              (clock),
        .rst                (rst),
        .enabled_in         (enabled_in),
        .response_in        (response_in),
        .cfg_write          (cfg_write),
        .cfg_index          (cfg_index),
        .cfg_window         (cfg_window),
        .response_out       (response_out),
        .response_count_out (response_count_out),
        .inject_count_out   (inject_count_out),
        .holdoff_out        (holdoff_out)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    response_fault_injector #(
        .NUM_WINDOWS       (4),
        .COUNT_WIDTH       (4),
        .HOLDOFF_RESPONSES (8)
    ) dut4 (
        .clock              (clock),
        .rst                (rst),
        .enabled_in         (enabled_in),
        .response_in        (response_in),
        .cfg_write          (cfg_write),
        .cfg_index          (cfg_index),
        .cfg_window         (cfg_window),
        .response_out       (resp4_out),
        .response_count_out (count4_out),
        .inject_count_out   (inject4_out),
        .holdoff_out        (holdoff4_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic response_interface_t make_resp(input logic v, input logic [7:0] tag,
                                                      input logic [7:0] code);
        response_interface_t r;
        r             = '0;
        r.valid       = v;
        r.tag         = tag;
        r.tag_parity  = ~^tag;
        r.response    = code;
        r.credits     = {1'b0, tag} ^ 9'h1A5;
        r.cache_state = tag[1:0];
        r.cache_pos   = {5'h15, tag};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Apply one response for a cycle; on return response_out holds its result.
    task automatic drive(input logic v, input logic [7:0] tag, input logic [7:0] code);
        response_in = make_resp(v, tag, code);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, RESP_DONE);
    endtask

    task automatic check_resp(input string name, input logic [7:0] tag, input logic [7:0] code);
        response_interface_t e;
        e = make_resp(1'b1, tag, code);
        check(name, 64'(response_out), 64'(e));
    endtask

    task automatic write_window(input logic [1:0] idx, input logic en, input logic [15:0] lo,
                                input logic [15:0] hi, input resp_code_e code);
        cfg_write         = 1'b1;
        cfg_index         = idx;
        cfg_window.enable = en;
        cfg_window.lo     = lo;
        cfg_window.hi     = hi;
        cfg_window.code   = code;
        idle();
        cfg_write = 1'b0;
    endtask

    task automatic restart();
        enabled_in = 1'b0;
        idle();
        enabled_in = 1'b1;
        idle();
    endtask

    initial begin
        logic [7:0] exp_code;

        rst         = 1'b1;
        enabled_in  = 1'b0;
        cfg_write   = 1'b0;
        cfg_index   = '0;
        cfg_window  = '0;
        response_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_resp", 64'(response_out), 64'd0);
        check("reset_count", 64'(response_count_out), 64'd0);
        check("reset_inject", 64'(inject_count_out), 64'd0);
        check("reset_holdoff", 64'(holdoff_out), 64'd0);
        check("reset_count4", 64'(count4_out), 64'd0);
        #2 rst = 1'b0;

        // Pass-through with no windows enabled.
        enabled_in = 1'b1;
        idle();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), RESP_DONE);
            check_resp("pass", 8'(i), RESP_DONE);
        end
        check("pass_count", 64'(response_count_out), 64'd20);
        check("pass_inject", 64'(inject_count_out), 64'd0);
        check("sat_count4", 64'(count4_out), 64'd15);

        // Single range window.
        write_window(2'd0, 1'b1, 16'd30, 16'd44, RESP_DERROR);
        restart();
        check("restart_count", 64'(response_count_out), 64'd0);
        check("restart_inject", 64'(inject_count_out), 64'd0);
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 8'(i), RESP_DONE);
            exp_code = (i >= 30 && i <= 44) ? RESP_DERROR : RESP_DONE;
            check_resp("range", 8'(i), exp_code);
        end
        check("range_inject", 64'(inject_count_out), 64'd15);
        check("range_count", 64'(response_count_out), 64'd50);

        // Overlapping windows and a genuine PAGED response.
        write_window(2'd0, 1'b1, 16'd100, 16'd119, RESP_AERROR);
        write_window(2'd1, 1'b1, 16'd100, 16'd200, RESP_FAULT);
        restart();
        for (int i = 0; i < 210; i++) begin
            drive(1'b1, 8'(i), (i == 105) ? RESP_PAGED : RESP_DONE);
            if (i == 105)                exp_code = RESP_PAGED;
            else if (i >= 100 && i <= 119) exp_code = RESP_AERROR;
            else if (i >= 120 && i <= 200) exp_code = RESP_FAULT;
            else                         exp_code = RESP_DONE;
            check_resp("prio", 8'(i), exp_code);
        end
        check("prio_inject", 64'(inject_count_out), 64'd100);
        check("prio_count", 64'(response_count_out), 64'd210);
        check("prio_holdoff", 64'(holdoff_out), 64'd0);

        // Injected PAGED followed by holdoff.
        write_window(2'd0, 1'b1, 16'd10, 16'd10, RESP_PAGED);
        write_window(2'd1, 1'b1, 16'd11, 16'd30, RESP_FLUSHED);
        restart();
        for (int i = 0; i < 35; i++) begin
            drive(1'b1, 8'(i), RESP_DONE);
            if (i == 10)                  exp_code = RESP_PAGED;
            else if (i >= 19 && i <= 30)  exp_code = RESP_FLUSHED;
            else                          exp_code = RESP_DONE;
            check_resp("holdoff_resp", 8'(i), exp_code);
            check("holdoff_flag", 64'(holdoff_out), 64'((i >= 10 && i <= 17) ? 1 : 0));
        end
        check("holdoff_inject", 64'(inject_count_out), 64'd13);

        // lo > hi never fires.
        write_window(2'd0, 1'b1, 16'd5, 16'd4, RESP_DERROR);
        write_window(2'd1, 1'b0, 16'd0, 16'd0, RESP_DONE);
        restart();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), RESP_DONE);
            check_resp("lo_gt_hi", 8'(i), RESP_DONE);
        end
        check("lo_gt_hi_inject", 64'(inject_count_out), 64'd0);

        // Window write in the same cycle as response 7.
        write_window(2'd0, 1'b0, 16'd0, 16'd0, RESP_DONE);
        restart();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(i), RESP_DONE);
        end
        cfg_write         = 1'b1;
        cfg_index         = 2'd2;
        cfg_window.enable = 1'b1;
        cfg_window.lo     = 16'd7;
        cfg_window.hi     = 16'd7;
        cfg_window.code   = RESP_FAULT;
        drive(1'b1, 8'd7, RESP_DONE);
        cfg_write = 1'b0;
        check_resp("cfg_same_cycle", 8'd7, RESP_DONE);
        drive(1'b1, 8'd8, RESP_DONE);
        check_resp("cfg_after", 8'd8, RESP_DONE);
        check("cfg_inject", 64'(inject_count_out), 64'd0);

        // Window retained across re-enable; enabled_in low still processes response 7.
        restart();
        check("reenable_count", 64'(response_count_out), 64'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(i), RESP_DONE);
        end
        enabled_in = 1'b0;
        drive(1'b1, 8'd7, RESP_DONE);
        check_resp("retained_inject", 8'd7, RESP_FAULT);
        drive(1'b1, 8'd7, RESP_DONE);
        check_resp("disabled_pass", 8'd7, RESP_DONE);
        check("disabled_count", 64'(response_count_out), 64'd8);
        check("disabled_inject", 64'(inject_count_out), 64'd1);

        // Asynchronous reset during a valid response.
        enabled_in = 1'b1;
        idle();
        drive(1'b1, 8'd3, RESP_DONE);
        check_resp("pre_rst", 8'd3, RESP_DONE);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 64'(response_out.valid), 64'd0);
        check("rst_count", 64'(response_count_out), 64'd0);
        check("rst_inject", 64'(inject_count_out), 64'd0);
        #2 rst = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), RESP_DONE);
            check_resp("rst_windows", 8'(i), RESP_DONE);
        end
        check("rst_windows_inject", 64'(inject_count_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/response_fault_injector.md
Name: response_fault_injector

Overview:
- Registered stage between the PSL response interface and afu_control; replaces the ad-hoc response latch/fault logic in the AFU top level.
- Counts valid PSL responses and, within MMIO-programmed response-count windows, overwrites the response code with a chosen error (PAGED, FLUSHED, FAULT, AERROR, DERROR).
- Used to exercise the restart/retry and error paths in simulation and on hardware.
- Tag, credits and all other response fields always pass through unmodified.

Parameters:
- NUM_WINDOWS, 4, number of programmable injection windows.
- COUNT_WIDTH, 16, width of the response counter and window bounds.
- HOLDOFF_RESPONSES, 8, responses passed untouched after an injected PAGED.

Ports:
- clock  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- enabled_in  in  1  job running, registered.
- response_in  in  ResponseInterface  raw PSL response.
- cfg_write  in  1  one-cycle window write strobe.
- cfg_index  in  $clog2(NUM_WINDOWS)  window selected by cfg_write.
- cfg_window  in  FaultWindow  {enable, lo[COUNT_WIDTH], hi[COUNT_WIDTH], code}.
- response_out  out  ResponseInterface  latched, possibly modified response to afu_control.
- response_count_out  out  COUNT_WIDTH  responses seen since enable.
- inject_count_out  out  32  responses modified since enable.
- holdoff_out  out  1  high while in HOLDOFF.

Behaviour:
- Reset (rst high, async):
  - response_out cleared to all-zero (valid=0).
  - Counters are 0.
  - All windows are disabled.
  - State is DISABLED; holdoff_out=0.
- Latency: exactly 1 cycle, response_in to response_out, in every state. response_out.valid follows response_in.valid with no bubbles or stalls.
- Pass-through fields: tag, tag_parity, credits and cache_state are copied verbatim. Only the response field may change.
- Parity: when response is modified, any response-field parity is regenerated for the new code.
- State DISABLED:
  - Pure pass-through; counters hold.
  - On rising enabled_in, clear both counters and go to ACTIVE.
  - Windows keep their contents.
- State ACTIVE:
  - Each valid response increments response_count (saturates at all-ones, no wrap).
  - A response is eligible only if its original code is DONE. Genuine non-DONE responses are never overwritten.
  - Match rule is evaluated on the pre-increment count: window.enable && lo <= count <= hi. A window with lo > hi never matches.
  - When several windows match, the lowest index wins.
  - On a match, response_out.response = window.code and inject_count increments (saturating).
  - If the injected code is PAGED, go to HOLDOFF with holdoff counter = HOLDOFF_RESPONSES.
- State HOLDOFF:
  - Responses pass unmodified but are still counted.
  - Holdoff counter decrements on each valid response.
  - When it reaches 0 after the last decrement, return to ACTIVE. A response that arrives in that same cycle is not injected.
  - holdoff_out = 1 in this state only.
- enabled_in low (from ACTIVE or HOLDOFF): go to DISABLED in the next cycle. A response arriving in the same cycle is still processed by the current state's rules.
- Configuration:
  - A cfg_write updates the window on the next clock edge.
  - A response arriving in the same cycle as the write is evaluated against the old window contents.
  - Writes are legal in any state.
- Reset mid-operation: all state, counters and windows clear immediately (async). response_out.valid drops without completing the in-flight response.

Decomposition:
- AFU_PKG additions:
  - FaultWindow struct.
  - InjectorState enum {DISABLED, ACTIVE, HOLDOFF}.
  - Default NUM_WINDOWS and HOLDOFF_RESPONSES constants.
- Response code enum: reused from CAPI_PKG.
- One natural sub-module: fault_window_match. It is combinational; it takes the window array, the count and an eligible flag, and returns hit and code. It performs a priority encode across the windows.
- The state machine, counters and output register stay in the parent.

Test Plan:
- Pass-through: no windows enabled, 20 DONE responses with tags 0..19. Expect identical response_out one cycle later, inject_count=0, response_count=20.
- Range window: window0 = {1, lo=30, hi=44, DERROR}, 50 DONE responses. Expect responses 30..44 to be DERROR, all others DONE, inject_count=15, tags and credits unchanged.
- Priority plus genuine PAGED:
  - Setup: window0 = {1, 100, 119, AERROR}, window1 = {1, 100, 200, FAULT}, genuine PAGED response at count 105.
  - Expect AERROR for counts 100..119 except 105, which stays PAGED.
  - Expect FAULT for counts 120..200.
- PAGED holdoff: window0 = {1, 10, 10, PAGED}, window1 = {1, 11, 30, FLUSHED}, HOLDOFF_RESPONSES=8.
  - Expect response 10 to be PAGED and holdoff_out high.
  - Expect responses 11..18 to be DONE.
  - Expect responses 19..30 to be FLUSHED.
- Boundaries:
  - window lo=5, hi=4: never fires.
  - COUNT_WIDTH=4 with 20 responses: count saturates at 15.
  - cfg_write in the same cycle as response 7, enabling a window over 7..7: response 7 is not injected.
- Reset and enable:
  - Assert rst during a valid response: response_out.valid=0 immediately and windows are cleared.
  - Toggle enabled_in low then high: both counters restart from 0 and windows are retained.
